// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and helpers for the maze-game round sequencer
package game_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      GEN    = 3'd1,
      PLAY   = 3'd2,
      JUDGE  = 3'd3,
      RESULT = 3'd4,
      OVER   = 3'd5
   } round_state_t;

   localparam int WIN_ALL = 0;
   localparam int WIN_ANY = 1;

   // diff is the already sign-extended BASE_WAIT - rating
   function automatic int clamp_wait(input int diff, input int min_wait);
      return (diff < min_wait) ? min_wait : diff;
   endfunction

endpackage

// File: rtl/round_countdown.sv
// rtl/round_countdown.sv - loadable per-second countdown with pause and zero flag
module round_countdown #(
   parameter int TIMER_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   arst,
   input  logic                   load,
   input  logic [TIMER_WIDTH-1:0] load_val,
   input  logic                   tick,
   input  logic                   pause,
   output logic [TIMER_WIDTH-1:0] count,
   output logic                   zero
);

   // a tick seen while paused is simply lost
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (tick && !pause && count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/game_round_ctrl.sv
// rtl/game_round_ctrl.sv - multi-ball round sequencer: regen, countdown, judge, lives and score
module game_round_ctrl
   import game_pkg::*;
#(
   parameter int SCREEN_WIDTH  = 400,
   parameter int SCREEN_HEIGHT = 600,
   parameter int N_BALLS       = 2,
   parameter int RATING_WIDTH  = 8,
   parameter int TIMER_WIDTH   = 8,
   parameter int BASE_WAIT     = 10,
   parameter int MIN_WAIT      = 2,
   parameter int INIT_LIVES    = 3,
   parameter int SCORE_WIDTH   = 16,
   parameter int WIN_MODE      = WIN_ALL,
   localparam int XW = $clog2(SCREEN_WIDTH),
   localparam int YW = $clog2(SCREEN_HEIGHT),
   localparam int LW = $clog2(INIT_LIVES + 1)
) (
   input  logic                    clk,
   input  logic                    arst,
   input  logic                    i_tick,
   input  logic                    i_start,
   input  logic                    i_pause,
   input  logic [RATING_WIDTH-1:0] i_rating,
   input  logic [N_BALLS*XW-1:0]   i_ball_x,
   input  logic [N_BALLS*YW-1:0]   i_ball_y,
   output logic                    o_regen,
   input  logic                    i_zone_rdy,
   output logic                    o_query_valid,
   output logic [XW-1:0]           o_query_x,
   output logic [YW-1:0]           o_query_y,
   input  logic                    i_is_safe,
   output logic [2:0]              o_state,
   output logic [TIMER_WIDTH-1:0]  o_time_left,
   output logic [N_BALLS-1:0]      o_safe_mask,
   output logic                    o_win,
   output logic                    o_lose,
   output logic                    o_game_over,
   output logic [LW-1:0]           o_lives,
   output logic [SCORE_WIDTH-1:0]  o_score
);

   localparam int CW = $clog2(N_BALLS + 1);
   localparam logic signed [RATING_WIDTH:0] BASE_S = (RATING_WIDTH + 1)'(BASE_WAIT);

   round_state_t              state;
   logic [1:0]                gen_cnt;
   logic [CW-1:0]             judge_cnt;
   logic [TIMER_WIDTH-1:0]    wait_lat;
   logic [N_BALLS*XW-1:0]     snap_x;
   logic [N_BALLS*YW-1:0]     snap_y;
   logic signed [RATING_WIDTH:0] wait_diff;
   logic [TIMER_WIDTH-1:0]    wait_val;
   logic [N_BALLS-1:0]        next_mask;
   logic                      judge_win;
   logic                      go_gen;
   logic                      cd_load;
   logic                      cd_tick;
   logic                      cd_zero;

   assign wait_diff = BASE_S - $signed({1'b0, i_rating});
   assign wait_val  = TIMER_WIDTH'(clamp_wait(int'(wait_diff), MIN_WAIT));

   assign cd_load = (state == GEN) && (gen_cnt == 2'd2) && i_zone_rdy;
   assign cd_tick = (state == PLAY) && i_tick;
   assign go_gen  = ((state == IDLE || state == OVER) && i_start) ||
                    (state == RESULT && o_lives != '0);

   round_countdown #(.TIMER_WIDTH(TIMER_WIDTH)) u_countdown (
      .clk      (clk),
      .arst     (arst),
      .load     (cd_load),
      .load_val (wait_lat),
      .tick     (cd_tick),
      .pause    (i_pause),
      .count    (o_time_left),
      .zero     (cd_zero)
   );

   // result for ball k arrives while judge_cnt == k+1
   always_comb begin
      next_mask = o_safe_mask;
      for (int k = 0; k < N_BALLS; k++) begin
         if (judge_cnt == CW'(k + 1)) next_mask[k] = i_is_safe;
      end
      judge_win = (WIN_MODE == WIN_ANY) ? |next_mask : &next_mask;
   end

   assign o_state = state;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state         <= IDLE;
         gen_cnt       <= '0;
         judge_cnt     <= '0;
         wait_lat      <= '0;
         snap_x        <= '0;
         snap_y        <= '0;
         o_regen       <= 1'b0;
         o_query_valid <= 1'b0;
         o_query_x     <= '0;
         o_query_y     <= '0;
         o_safe_mask   <= '0;
         o_win         <= 1'b0;
         o_lose        <= 1'b0;
         o_game_over   <= 1'b0;
         o_lives       <= LW'(INIT_LIVES);
         o_score       <= '0;
      end else begin
         o_regen <= 1'b0;
         o_win   <= 1'b0;
         o_lose  <= 1'b0;

         case (state)
            IDLE: begin
               if (i_start) begin
                  o_lives <= LW'(INIT_LIVES);
                  o_score <= '0;
               end
            end
            GEN: begin
               // zone_rdy may still be high from the previous level for two cycles
               if (gen_cnt != 2'd2) begin
                  gen_cnt <= gen_cnt + 1'b1;
               end else if (i_zone_rdy) begin
                  state <= PLAY;
               end
            end
            PLAY: begin
               if (cd_zero) begin
                  state         <= JUDGE;
                  judge_cnt     <= '0;
                  o_query_valid <= 1'b1;
                  o_query_x     <= i_ball_x[XW-1:0];
                  o_query_y     <= i_ball_y[YW-1:0];
                  snap_x        <= i_ball_x >> XW;
                  snap_y        <= i_ball_y >> YW;
               end
            end
            JUDGE: begin
               judge_cnt <= judge_cnt + 1'b1;
               if (int'(judge_cnt) + 1 < N_BALLS) begin
                  o_query_valid <= 1'b1;
                  o_query_x     <= snap_x[XW-1:0];
                  o_query_y     <= snap_y[YW-1:0];
                  snap_x        <= snap_x >> XW;
                  snap_y        <= snap_y >> YW;
               end else begin
                  o_query_valid <= 1'b0;
               end
               if (judge_cnt != '0) o_safe_mask <= next_mask;
               if (judge_cnt == CW'(N_BALLS)) begin
                  state <= RESULT;
                  if (judge_win) begin
                     o_win <= 1'b1;
                     if (o_score != '1) o_score <= o_score + 1'b1;
                  end else begin
                     o_lose  <= 1'b1;
                     o_lives <= o_lives - 1'b1;
                  end
               end
            end
            RESULT: begin
               if (o_lives == '0) begin
                  state       <= OVER;
                  o_game_over <= 1'b1;
               end
            end
            OVER: begin
               if (i_start) begin
                  o_lives     <= LW'(INIT_LIVES);
                  o_score     <= '0;
                  o_game_over <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase

         if (go_gen) begin
            state    <= GEN;
            o_regen  <= 1'b1;
            gen_cnt  <= '0;
            wait_lat <= wait_val;
         end
      end
   end

endmodule
